// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// with memory handshakes, a per-request wait timeout and a retired-instruction count.
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        has_rd,
    input  logic        take_branch,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] instret
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_FAULT     = 3'd6;

    // The counter only has to reach MEM_TIMEOUT-1: the last waiting cycle is
    // recognised by its current value, so MEM_TIMEOUT itself is never stored.
    localparam int              CNT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam bit              TMO_EN    = (MEM_TIMEOUT > 0);

    logic [2:0]       state_q,   state_d;
    logic             take_q,    take_d;
    logic [CNT_W-1:0] wait_q,    wait_d;
    logic [31:0]      instret_q, instret_d;
    logic             fault_q,   fault_d;
    logic             wait_hit;

    always_comb begin
        state_d   = state_q;
        take_d    = take_q;
        wait_d    = wait_q;
        instret_d = instret_q;
        wait_hit  = TMO_EN && (wait_q == WAIT_LAST);

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                take_d = take_branch;
                if (is_load || is_store) begin
                    state_d = S_MEMORY;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (dmem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                instret_d = instret_q + 32'd1;
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        fault_d = fault_q || (state_d == S_FAULT);
    end

    // Strobes are forced low during reset even though the state register
    // only clears on the next edge.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_MEMORY: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                end
                S_WRITEBACK: begin
                    pc_we  = 1'b1;
                    pc_src = take_q;
                    rf_we  = has_rd && !is_store;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            take_q    <= 1'b0;
            wait_q    <= '0;
            instret_q <= 32'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            take_q    <= take_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
        end
    end

    assign state   = state_q;
    assign fault   = fault_q;
    assign instret = instret_q;

endmodule
